// File: rtl/ctrl_unit.sv
// ctrl_unit: multicycle control FSM for the 10-bit processor.
// Loads the IR in T0, then sequences register-file, bus-mux, A/G and ALU
// enables over T1..T3, pulsing done in the last timestep of each instruction.
module ctrl_unit #(
  parameter int unsigned IW   = 10,
  parameter int unsigned NREG = 8
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            run,
  input  logic [IW-1:0]   instr,
  output logic            ir_write,
  output logic [NREG-1:0] reg_in,
  output logic [NREG-1:0] reg_out,
  output logic            din_out,
  output logic            a_in,
  output logic            g_in,
  output logic            g_out,
  output logic [2:0]      alu_op,
  output logic            done
);

  typedef enum logic [1:0] {
    T0 = 2'd0,
    T1 = 2'd1,
    T2 = 2'd2,
    T3 = 2'd3
  } state_t;

  typedef enum logic [3:0] {
    OP_MV  = 4'b0000,
    OP_MVI = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0011,
    OP_AND = 4'b0100,
    OP_OR  = 4'b0101
  } opcode_t;

  state_t     state_q, state_d;
  opcode_t    opcode;
  logic [2:0] rx, ry;
  logic       is_alu;

  assign opcode = opcode_t'(instr[IW-1 -: 4]);
  assign rx     = instr[5:3];
  assign ry     = instr[2:0];
  assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                  (opcode == OP_AND) || (opcode == OP_OR);

  // Timestep register; asynchronous reset returns to T0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= T0;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and control decode from timestep, opcode and run.
  always_comb begin
    state_d  = state_q;
    ir_write = 1'b0;
    reg_in   = '0;
    reg_out  = '0;
    din_out  = 1'b0;
    a_in     = 1'b0;
    g_in     = 1'b0;
    g_out    = 1'b0;
    alu_op   = 3'b000;
    done     = 1'b0;

    unique case (state_q)
      T0: begin
        ir_write = run;
        if (run) begin
          state_d = T1;
        end
      end

      T1: begin
        case (opcode)
          OP_MV: begin
            reg_out[ry] = 1'b1;
            reg_in[rx]  = 1'b1;
            done        = 1'b1;
            state_d     = T0;
          end
          OP_MVI: begin
            din_out    = 1'b1;
            reg_in[rx] = 1'b1;
            done       = 1'b1;
            state_d    = T0;
          end
          OP_ADD, OP_SUB, OP_AND, OP_OR: begin
            reg_out[rx] = 1'b1;
            a_in        = 1'b1;
            state_d     = T2;
          end
          default: begin
            // Illegal opcode completes as a NOP.
            done    = 1'b1;
            state_d = T0;
          end
        endcase
      end

      T2: begin
        state_d = T0;
        if (is_alu) begin
          reg_out[ry] = 1'b1;
          g_in        = 1'b1;
          state_d     = T3;
          case (opcode)
            OP_SUB:  alu_op = 3'b001;
            OP_AND:  alu_op = 3'b010;
            OP_OR:   alu_op = 3'b011;
            default: alu_op = 3'b000;
          endcase
        end
      end

      T3: begin
        state_d = T0;
        if (is_alu) begin
          g_out      = 1'b1;
          reg_in[rx] = 1'b1;
          done       = 1'b1;
        end
      end

      default: state_d = T0;
    endcase

    // Outputs are forced low for the whole time reset is held, even though
    // the state register already reads T0.
    if (reset) begin
      ir_write = 1'b0;
      reg_in   = '0;
      reg_out  = '0;
      din_out  = 1'b0;
      a_in     = 1'b0;
      g_in     = 1'b0;
      g_out    = 1'b0;
      alu_op   = 3'b000;
      done     = 1'b0;
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// Self-checking bench for ctrl_unit: directed scenarios plus randomized
// instruction streams checked against a per-timestep micro-op table model.
module tb_ctrl_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       run   = 1'b0;
  logic [9:0] instr = '0;
  logic       ir_write;
  logic [7:0] reg_in, reg_out;
  logic       din_out, a_in, g_in, g_out, done;
  logic [2:0] alu_op;

  int total = 0;
  int bad   = 0;
  int cycle = 0;
  int last_done_cycle = -1;

  ctrl_unit #(.IW(10), .NREG(8)) dut (
    .clock   (clock),
    .reset   (reset),
    .run     (run),
    .instr   (instr),
    .ir_write(ir_write),
    .reg_in  (reg_in),
    .reg_out (reg_out),
    .din_out (din_out),
    .a_in    (a_in),
    .g_in    (g_in),
    .g_out   (g_out),
    .alu_op  (alu_op),
    .done    (done)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  function automatic logic [24:0] observed();
    return {ir_write, reg_in, reg_out, din_out, a_in, g_in, g_out, alu_op, done};
  endfunction

  function automatic bit is_alu_op(input logic [9:0] ins);
    return (ins[9:6] >= 4'd2) && (ins[9:6] <= 4'd5);
  endfunction

  // Number of timesteps after T0 until done.
  function automatic int steps_of(input logic [9:0] ins);
    return is_alu_op(ins) ? 3 : 1;
  endfunction

  // Expected control word for timestep k (0 = T0) of instruction ins.
  function automatic logic [24:0] exp_vec(input logic [9:0] ins, input int k);
    logic [7:0] ri, ro;
    logic       ir, din, a, gi, go, dn;
    logic [2:0] op;
    logic [3:0] opc;
    logic [2:0] rx, ry;
    ri = '0; ro = '0; ir = 0; din = 0; a = 0; gi = 0; go = 0; dn = 0; op = '0;
    opc = ins[9:6]; rx = ins[5:3]; ry = ins[2:0];
    if (k == 0) begin
      ir = 1'b1;
    end else if (opc == 4'd0) begin
      ro = 8'b1 << ry; ri = 8'b1 << rx; dn = 1'b1;
    end else if (opc == 4'd1) begin
      din = 1'b1; ri = 8'b1 << rx; dn = 1'b1;
    end else if (is_alu_op(ins)) begin
      if (k == 1) begin
        ro = 8'b1 << rx; a = 1'b1;
      end else if (k == 2) begin
        ro = 8'b1 << ry; gi = 1'b1;
        case (opc)
          4'd2: op = 3'b000;
          4'd3: op = 3'b001;
          4'd4: op = 3'b010;
          default: op = 3'b011;
        endcase
      end else begin
        go = 1'b1; ri = 8'b1 << rx; dn = 1'b1;
      end
    end else begin
      dn = 1'b1;
    end
    return {ir, ri, ro, din, a, gi, go, op, dn};
  endfunction

  // Issues one instruction from T0 and checks every timestep.
  // hold_run=1 keeps run high throughout (back-to-back issue).
  task automatic do_instr(input logic [9:0] ins, input bit hold_run);
    logic [24:0] e;
    int done_k;
    int exp_lat;
    done_k = -1;
    exp_lat = (ins[9:6] >= 4'd2 && ins[9:6] <= 4'd5) ? 3 : 1;
    @(negedge clock);
    run = 1'b1; instr = ins; #1;
    e = exp_vec(ins, 0);
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL t0_%h: got %h expected %h", ins, observed(), e);
    end
    for (int k = 1; k <= steps_of(ins); k++) begin
      @(negedge clock);
      run = hold_run ? 1'b1 : 1'($urandom_range(0, 1)); #1;
      e = exp_vec(ins, k);
      total++;
      if (observed() !== e) begin
        bad++;
        $display("FAIL step%0d_%h: got %h expected %h", k, ins, observed(), e);
      end
      if (done === 1'b1 && done_k < 0) begin
        done_k = k;
        last_done_cycle = cycle;
      end
    end
    total++;
    if (done_k != exp_lat) begin
      bad++;
      $display("FAIL latency_%h: got %0d expected %0d", ins, done_k, exp_lat);
    end
  endtask

  // Idle T0 cycles with run low: everything stays 0.
  task automatic idle(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      run = 1'b0; instr = 10'($urandom); #1;
      total++;
      if (observed() !== 25'd0) begin
        bad++;
        $display("FAIL %s: got %h expected %h", name, observed(), 25'd0);
      end
    end
  endtask

  task automatic test_reset();
    run = 1'b1; instr = 10'b0010_000_001; #1;
    total++;
    if (observed() !== 25'd0) begin
      bad++;
      $display("FAIL reset_outputs: got %h expected %h", observed(), 25'd0);
    end
    @(posedge clock); #1;
    total++;
    if (observed() !== 25'd0) begin
      bad++;
      $display("FAIL reset_held: got %h expected %h", observed(), 25'd0);
    end
    @(negedge clock);
    reset = 1'b0; run = 1'b0;
    idle(2, "reset_idle");
  endtask

  task automatic test_directed();
    do_instr(10'b0000_010_011, 1'b0);   // mv r2,r3
    do_instr(10'b0001_101_000, 1'b0);   // mvi r5
    do_instr(10'b0011_001_110, 1'b0);   // sub r1,r6
    do_instr(10'b0000_011_011, 1'b0);   // mv r3,r3
    idle(1, "directed_idle");
  endtask

  task automatic test_back_to_back();
    int d1, d2, d3;
    do_instr(10'b0010_000_111, 1'b1);   // add r0,r7
    d1 = last_done_cycle;
    do_instr(10'b0101_100_100, 1'b1);   // or r4,r4
    d2 = last_done_cycle;
    do_instr(10'b0100_110_010, 1'b1);   // and r6,r2
    d3 = last_done_cycle;
    total++;
    if (d2 - d1 != 4) begin
      bad++;
      $display("FAIL b2b_gap1: got %0d expected %0d", d2 - d1, 4);
    end
    total++;
    if (d3 - d2 != 4) begin
      bad++;
      $display("FAIL b2b_gap2: got %0d expected %0d", d3 - d2, 4);
    end
    idle(1, "b2b_idle");
  endtask

  task automatic test_illegal();
    do_instr(10'b1111_000_000, 1'b0);
    idle(3, "illegal_idle");
  endtask

  task automatic test_reset_mid();
    logic [9:0] ins;
    logic [24:0] e;
    ins = 10'b0011_010_101;   // sub r2,r5
    @(negedge clock); run = 1'b1; instr = ins;
    @(negedge clock); run = 1'b0;           // T1
    @(negedge clock); #1;                   // T2
    e = exp_vec(ins, 2);
    total++;
    if (observed() !== e) begin
      bad++;
      $display("FAIL midrst_t2: got %h expected %h", observed(), e);
    end
    run = 1'b1; #1;
    reset = 1'b1; #1;
    total++;
    if (observed() !== 25'd0) begin
      bad++;
      $display("FAIL midrst_async: got %h expected %h", observed(), 25'd0);
    end
    @(posedge clock); #1;
    total++;
    if (observed() !== 25'd0) begin
      bad++;
      $display("FAIL midrst_held: got %h expected %h", observed(), 25'd0);
    end
    @(negedge clock);
    reset = 1'b0; run = 1'b0;
    idle(2, "midrst_idle");
    do_instr(10'b0000_001_100, 1'b0);       // mv r1,r4 from a clean T0
  endtask

  task automatic test_random();
    logic [9:0] ins;
    for (int i = 0; i < 150; i++) begin
      ins = 10'($urandom);
      if ($urandom_range(0, 3) != 0) ins[9:6] = 4'($urandom_range(0, 5));
      do_instr(ins, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)), "rand_idle");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got %0d cycles expected completion", cycle);
    $fatal(1);
  end

endmodule
